trivium_keystream_gen: RTL and testbench

//  Trivium keystream generator (80-bit key, 80-bit IV, 288-bit state).

---
 rtl/trivium_pkg.sv | 64 ++++++
 rtl/trivium_keystream_gen.sv | 102 ++++++++++
 tb/tb_trivium_keystream_gen.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/trivium_pkg.sv
// Shared Trivium definitions: widths, FSM states, tap positions and the
// combinational state-update function used by the keystream generator.
package trivium_pkg;

   localparam int KEY_W   = 80;
   localparam int IV_W    = 80;
   localparam int STATE_W = 288;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      RUN  = 2'd2
   } state_t;

   // Tap positions use the cipher's 1-based numbering (s1..s288).
   localparam int T1_A   = 66;
   localparam int T1_B   = 93;
   localparam int T1_N0  = 91;
   localparam int T1_N1  = 92;
   localparam int T1_X   = 171;
   localparam int T2_A   = 162;
   localparam int T2_B   = 177;
   localparam int T2_N0  = 175;
   localparam int T2_N1  = 176;
   localparam int T2_X   = 264;
   localparam int T3_A   = 243;
   localparam int T3_B   = 288;
   localparam int T3_N0  = 286;
   localparam int T3_N1  = 287;
   localparam int T3_X   = 69;

   typedef struct packed {
      logic [STATE_W-1:0] s;
      logic               z;
   } step_t;

   // Bit i of the packed state holds s(i+1).
   function automatic step_t trivium_step(input logic [STATE_W-1:0] s);
      step_t r;
      logic  t1;
      logic  t2;
      logic  t3;
      t1 = s[T1_A-1] ^ s[T1_B-1];
      t2 = s[T2_A-1] ^ s[T2_B-1];
      t3 = s[T3_A-1] ^ s[T3_B-1];
      r.z = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[T1_N0-1] & s[T1_N1-1]) ^ s[T1_X-1];
      t2 = t2 ^ (s[T2_N0-1] & s[T2_N1-1]) ^ s[T2_X-1];
      t3 = t3 ^ (s[T3_N0-1] & s[T3_N1-1]) ^ s[T3_X-1];
      r.s = {s[286:177], t2, s[175:93], t1, s[91:0], t3};
      return r;
   endfunction

   function automatic logic [STATE_W-1:0] trivium_load(input logic [KEY_W-1:0] key,
                                                        input logic [IV_W-1:0]  iv);
      logic [STATE_W-1:0] s;
      s          = '0;
      s[79:0]    = key;
      s[172:93]  = iv;
      s[287:285] = 3'b111;
      return s;
   endfunction

endpackage

// File: rtl/trivium_keystream_gen.sv
// Trivium keystream generator: warm-up FSM, 288-bit state register and an
// LSB-first byte packer that writes straight into a downstream byte FIFO.
module trivium_keystream_gen
   import trivium_pkg::*;
#(
   parameter int INIT_STEPS = 1152,
   parameter int OUT_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [KEY_W-1:0]  key,
   input  logic [IV_W-1:0]   iv,
   input  logic              full,
   output logic [OUT_W-1:0]  dout,
   output logic              write,
   output logic              busy,
   output logic              ready
);

   localparam logic [10:0] INIT_LAST = 11'(INIT_STEPS - 1);
   localparam logic [2:0]  BIT_LAST  = 3'(OUT_W - 1);

   state_t             state_q, state_d;
   logic [STATE_W-1:0] s_q, s_d;
   logic [10:0]        init_cnt_q, init_cnt_d;
   logic [2:0]         bit_cnt_q, bit_cnt_d;
   logic [OUT_W-1:0]   acc_q, acc_d;
   logic [OUT_W-1:0]   dout_q, dout_d;
   logic               write_q, write_d;
   step_t              nxt;
   logic               last_bit;

   assign nxt      = trivium_step(s_q);
   assign last_bit = (bit_cnt_q == BIT_LAST);

   always_comb begin
      state_d    = state_q;
      s_d        = s_q;
      init_cnt_d = init_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      acc_d      = acc_q;
      dout_d     = dout_q;
      write_d    = 1'b0;
      if (start) begin
         state_d    = INIT;
         s_d        = trivium_load(key, iv);
         init_cnt_d = '0;
         bit_cnt_d  = '0;
         acc_d      = '0;
      end else begin
         case (state_q)
            INIT: begin
               s_d        = nxt.s;
               init_cnt_d = init_cnt_q + 11'd1;
               if (init_cnt_q == INIT_LAST) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               // Only the byte-completing step waits on full, so a strobe never meets a full FIFO.
               if (!(full && last_bit)) begin
                  s_d               = nxt.s;
                  acc_d[bit_cnt_q]  = nxt.z;
                  bit_cnt_d         = bit_cnt_q + 3'd1;
                  if (last_bit) begin
                     dout_d  = {nxt.z, acc_q[OUT_W-2:0]};
                     write_d = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         s_q        <= '0;
         init_cnt_q <= '0;
         bit_cnt_q  <= '0;
         acc_q      <= '0;
         dout_q     <= '0;
         write_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         s_q        <= s_d;
         init_cnt_q <= init_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         acc_q      <= acc_d;
         dout_q     <= dout_d;
         write_q    <= write_d;
      end
   end

   assign dout  = dout_q;
   assign write = write_q;
   assign busy  = (state_q == INIT);
   assign ready = (state_q == RUN);

endmodule

// File: tb/tb_trivium_keystream_gen.sv
// Directed bench for trivium_keystream_gen: timing, packing, stall, restart
// and asynchronous reset, checked against a bit-level model of the cipher.
module tb_trivium_keystream_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        start16;
   logic        full;
   logic [79:0] key;
   logic [79:0] iv;
   logic [7:0]  dout, dout16;
   logic        write, write16;
   logic        busy, busy16;
   logic        ready, ready16;

   int total = 0;
   int bad   = 0;

   logic [288:1] model_a;
   logic [288:1] model_b;

   always #5 clk = ~clk;

   trivium_keystream_gen #(.INIT_STEPS(1152), .OUT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .key(key), .iv(iv), .full(full),
      .dout(dout), .write(write), .busy(busy), .ready(ready)
   );

   trivium_keystream_gen #(.INIT_STEPS(16), .OUT_W(8)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .key(key), .iv(iv), .full(full),
      .dout(dout16), .write(write16), .busy(busy16), .ready(ready16)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model indexed exactly like the cipher description: st[n] is s(n).
   task automatic modelLoad(output logic [288:1] st, input logic [79:0] k, input logic [79:0] v);
      st          = '0;
      st[80:1]    = k;
      st[173:94]  = v;
      st[288:286] = 3'b111;
   endtask

   task automatic modelStep(inout logic [288:1] st, output logic z);
      logic t1, t2, t3;
      t1 = st[66] ^ st[93];
      t2 = st[162] ^ st[177];
      t3 = st[243] ^ st[288];
      z  = t1 ^ t2 ^ t3;
      t1 = t1 ^ (st[91] & st[92]) ^ st[171];
      t2 = t2 ^ (st[175] & st[176]) ^ st[264];
      t3 = t3 ^ (st[286] & st[287]) ^ st[69];
      st = {st[287:178], t2, st[176:94], t1, st[92:1], t3};
   endtask

   task automatic modelWarm(inout logic [288:1] st, input int n);
      logic z;
      for (int i = 0; i < n; i++) modelStep(st, z);
   endtask

   task automatic modelByte(inout logic [288:1] st, output logic [7:0] b);
      logic z;
      for (int i = 0; i < 8; i++) begin
         modelStep(st, z);
         b[i] = z;
      end
   endtask

   task automatic applyStimulus(input bit use16, input logic [79:0] k, input logic [79:0] v);
      @(negedge clk);
      key = k;
      iv  = v;
      if (use16) start16 = 1'b1;
      else       start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      start16 = 1'b0;
   endtask

   task automatic waitReady(input string tag, input bit use16, input int exp_cycles);
      int cnt = 0;
      int wr  = 0;
      while (!(use16 ? ready16 : ready) && cnt < exp_cycles + 50) begin
         @(negedge clk);
         cnt++;
         if (use16 ? write16 : write) wr++;
      end
      checkOutput({tag, "_init_cycles"}, cnt, exp_cycles);
      checkOutput({tag, "_init_writes"}, wr, 0);
   endtask

   task automatic getByte(input string tag, input bit use16, inout logic [288:1] st);
      logic [7:0] exp;
      int n = 0;
      modelByte(st, exp);
      while (!(use16 ? write16 : write) && n < 40) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_strobe"}, use16 ? write16 : write, 1);
      checkOutput({tag, "_byte"}, use16 ? dout16 : dout, exp);
      @(negedge clk);
   endtask

   initial begin
      int n;
      int wr;
      int got;
      logic [7:0] exp;
      rst = 1'b1; start = 1'b0; start16 = 1'b0; full = 1'b0;
      key = '0; iv = '0;
      #12;
      checkOutput("reset_write", write, 0);
      checkOutput("reset_dout", dout, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_ready", ready, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("idle_busy", busy, 0);

      $display("[TB] short warm-up, key=1 iv=0");
      applyStimulus(1'b1, 80'h1, 80'h0);
      modelLoad(model_b, 80'h1, 80'h0);
      modelWarm(model_b, 16);
      checkOutput("t2_busy", busy16, 1);
      waitReady("t2", 1'b1, 16);
      for (int i = 0; i < 4; i++) getByte($sformatf("t2_b%0d", i), 1'b1, model_b);

      $display("[TB] full warm-up, key=0 iv=0");
      applyStimulus(1'b0, 80'h0, 80'h0);
      modelLoad(model_a, 80'h0, 80'h0);
      modelWarm(model_a, 1152);
      checkOutput("t1_busy", busy, 1);
      checkOutput("t1_ready", ready, 0);
      waitReady("t1", 1'b0, 1152);
      n = 0;
      while (!write && n < 40) begin
         @(negedge clk);
         n++;
      end
      checkOutput("t1_first_write_delay", n, 8);
      for (int i = 0; i < 64; i++) getByte($sformatf("t1_b%0d", i), 1'b0, model_a);

      $display("[TB] back-pressure on byte boundary");
      full = 1'b1;
      wr = 0;
      for (int i = 0; i < 26; i++) begin
         @(negedge clk);
         if (write) wr++;
      end
      checkOutput("t3_stall_writes", wr, 0);
      full = 1'b0;
      @(negedge clk);
      checkOutput("t3_release_strobe", write, 1);
      getByte("t3_release", 1'b0, model_a);
      for (int i = 0; i < 4; i++) getByte($sformatf("t3_after%0d", i), 1'b0, model_a);

      $display("[TB] restart mid-byte");
      repeat (2) @(negedge clk);
      applyStimulus(1'b0, 80'h0123_4567_89AB_CDEF_F00D, 80'hFEDC_BA98_7654_3210_BEEF);
      modelLoad(model_a, 80'h0123_4567_89AB_CDEF_F00D, 80'hFEDC_BA98_7654_3210_BEEF);
      modelWarm(model_a, 1152);
      checkOutput("t4_write", write, 0);
      checkOutput("t4_busy", busy, 1);
      checkOutput("t4_ready", ready, 0);
      waitReady("t4", 1'b0, 1152);
      for (int i = 0; i < 8; i++) getByte($sformatf("t4_b%0d", i), 1'b0, model_a);

      $display("[TB] random back-pressure");
      got = 0;
      n = 0;
      while (got < 30 && n < 2000) begin
         @(negedge clk);
         n++;
         if (write) begin
            modelByte(model_a, exp);
            checkOutput($sformatf("t6_b%0d", got), dout, exp);
            got++;
         end
         full = ($urandom_range(0, 1) == 1);
      end
      full = 1'b0;
      checkOutput("t6_count", got, 30);

      $display("[TB] async reset mid-INIT");
      applyStimulus(1'b0, 80'hAAAA, 80'h5555);
      repeat (100) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("t5i_busy", busy, 0);
      checkOutput("t5i_ready", ready, 0);
      checkOutput("t5i_write", write, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("t5i_stays_idle", busy, 0);

      $display("[TB] async reset mid-RUN");
      applyStimulus(1'b0, 80'h1234, 80'h9876);
      waitReady("t5r", 1'b0, 1152);
      n = 0;
      while (!write && n < 40) begin
         @(negedge clk);
         n++;
      end
      checkOutput("t5r_pre_strobe", write, 1);
      #1 rst = 1'b1;
      #1;
      checkOutput("t5r_write", write, 0);
      checkOutput("t5r_dout", dout, 0);
      checkOutput("t5r_ready", ready, 0);
      checkOutput("t5r_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
